// File: rtl/qsic_pkg.sv
// Shared QSIC definitions: interrupt FSM state encoding, QBUS request levels,
// and the synchronizer depth used by every raw bus receiver in the block.
package qsic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_VEC   = 3'd2,
        ST_REPLY = 3'd3,
        ST_DONE  = 3'd4,
        ST_PASS  = 3'd5
    } qint_state_t;

    localparam logic [1:0] BR4 = 2'd0;
    localparam logic [1:0] BR5 = 2'd1;
    localparam logic [1:0] BR6 = 2'd2;
    localparam logic [1:0] BR7 = 2'd3;

    localparam int SYNC_STAGES = 2;

    function automatic logic [3:0] level_onehot(input logic [1:0] lvl);
        return 4'b0001 << lvl;
    endfunction

endpackage

// File: rtl/qint_if.sv
// QBUS interrupt lines and DAL transceiver controls between qint (master)
// and the bus/transceiver side (slave).
interface qint_if;

    logic        RSYNC;
    logic        RDIN;
    logic        RIAKI;
    logic [3:0]  RIRQ;
    logic [3:0]  TIRQ;
    logic        TIAKO;
    logic        TRPLY;
    logic [15:0] vec_dal;
    logic        vec_oe;
    logic        vec_st;

    modport master (
        input  RSYNC, RDIN, RIAKI, RIRQ,
        output TIRQ, TIAKO, TRPLY, vec_dal, vec_oe, vec_st
    );

    modport slave (
        output RSYNC, RDIN, RIAKI, RIRQ,
        input  TIRQ, TIAKO, TRPLY, vec_dal, vec_oe, vec_st
    );

endinterface

// File: rtl/qsync2.sv
// Multi-flop synchronizer (SYNC_STAGES deep) for raw QBUS receivers; also
// usable by the register block.
module qsync2
    import qsic_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/qint.sv
// QBUS interrupt controller: selects a requester, drives BIRQ, answers IAK with a vector or passes IAKO.
// Define QINT_RR_EN for round-robin requester selection; otherwise fixed priority (index 0 highest).
module qint
    import qsic_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int IDX_BITS = 2
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic [8:0]         int_vector,
    input  logic [1:0]         int_priority,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   ack,
    output logic               busy,
    qint_if.master             bus
);

    // state | meaning
    // IDLE  | nothing requested, no acknowledge in progress
    // REQ   | BIRQ at int_priority asserted, waiting for DIN+IAKI
    // VEC   | vector driven onto DAL and latched
    // REPLY | RPLY asserted until DIN drops; ack pulses on entry
    // DONE  | reply removed, waiting for IAKI to drop
    // PASS  | acknowledge not ours, IAKO asserted until IAKI drops

    qint_state_t          state_q, state_d;
    logic [N_REQ-1:0]     pend_q;
    logic [IDX_BITS-1:0]  sel, win_q, win_d;
    logic                 first_q;
    logic                 s_din, s_iak, s_sync;
    logic [3:0]           s_irq;
    logic [3:0]           above_mask;
    logic                 iak, blocked, ack_pulse;
    logic [6:0]           vec_word;
    logic [3:0]           tirq;
    logic                 tiako, trply, vec_oe, vec_st;

    qsync2 #(.WIDTH(1)) u_sync_din  (.clk(clk), .reset_L(reset_L), .d_i(bus.RDIN),  .q_o(s_din));
    qsync2 #(.WIDTH(1)) u_sync_iak  (.clk(clk), .reset_L(reset_L), .d_i(bus.RIAKI), .q_o(s_iak));
    qsync2 #(.WIDTH(1)) u_sync_sync (.clk(clk), .reset_L(reset_L), .d_i(bus.RSYNC), .q_o(s_sync));
    qsync2 #(.WIDTH(4)) u_sync_irq  (.clk(clk), .reset_L(reset_L), .d_i(bus.RIRQ),  .q_o(s_irq));

    // SYNC belongs to the register interface; vector bits [1:0] are fixed to 0 on the DAL.
    logic unused_ok;
    assign unused_ok = ^{int_vector[1:0], s_sync};

    assign iak        = s_din && s_iak;
    assign above_mask = 4'b1110 << int_priority;
    assign blocked    = |(s_irq & above_mask);

`ifdef QINT_RR_EN
    logic [IDX_BITS-1:0] ptr_q;

    // Lowest pending index overall, overridden by the lowest one above the pointer.
    always_comb begin
        sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = IDX_BITS'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pend_q[i] && (i > int'(ptr_q))) sel = IDX_BITS'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr_q <= '0;
        end else if (ack_pulse) begin
            ptr_q <= win_q;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = IDX_BITS'(i);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            win_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= req;
            win_q   <= win_d;
            first_q <= (state_q == ST_VEC);
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        tirq    = '0;
        tiako   = 1'b0;
        trply   = 1'b0;
        vec_oe  = 1'b0;
        vec_st  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iak) begin
                    state_d = ST_PASS;
                end else if (|pend_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                tirq = level_onehot(int_priority);
                if (pend_q == '0) begin
                    state_d = ST_IDLE;
                end else if (iak) begin
                    if (blocked) begin
                        state_d = ST_PASS;
                    end else begin
                        win_d   = sel;
                        state_d = ST_VEC;
                    end
                end
            end
            ST_VEC: begin
                vec_oe  = 1'b1;
                vec_st  = 1'b1;
                state_d = ST_REPLY;
            end
            ST_REPLY: begin
                trply  = 1'b1;
                vec_oe = 1'b1;
                if (!s_din) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!s_iak) state_d = ST_IDLE;
            end
            ST_PASS: begin
                tiako = 1'b1;
                if (!s_iak) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign vec_word  = int_vector[8:2] + 7'(win_q);
    assign ack_pulse = (state_q == ST_REPLY) && first_q;
    assign ack       = ack_pulse ? (N_REQ'(1) << win_q) : '0;
    assign busy      = (state_q != ST_IDLE);

    assign bus.TIRQ    = tirq;
    assign bus.TIAKO   = tiako;
    assign bus.TRPLY   = trply;
    assign bus.vec_oe  = vec_oe;
    assign bus.vec_st  = vec_st;
    assign bus.vec_dal = vec_oe ? {7'b0, vec_word, 2'b00} : '0;

endmodule

// File: tb/tb_qint.sv
// Self-checking bench for qint: directed IAK scenarios plus randomized IAK transactions
// checked against a behavioural model of selection, level blocking and vector arithmetic.
module tb_qint;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_L;
    logic [8:0]     int_vector;
    logic [1:0]     int_priority;
    logic [N-1:0]   req;
    logic [N-1:0]   ack;
    logic           busy;

    qint_if bus ();

    qint #(.N_REQ(N), .IDX_BITS(2)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .int_vector   (int_vector),
        .int_priority (int_priority),
        .req          (req),
        .ack          (ack),
        .busy         (busy),
        .bus          (bus)
    );

    always #25 clk = ~clk;

    int checks;
    int errors;
    int model_ptr;

    int          s_vst, s_trply, s_tiako, s_ack_cnt, s_ack_idx;
    bit          s_oe, s_overlap;
    logic [15:0] s_vdal;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester the model grants next, or -1 when nothing is pending.
    function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
`ifdef QINT_RR_EN
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (pend[idx]) return idx;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (pend[k]) return k;
        end
`endif
        return -1;
    endfunction

    function automatic bit model_blocked(input int prio, input logic [3:0] rirq);
        for (int b = prio + 1; b < 4; b++) begin
            if (rirq[b]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int model_vec(input logic [8:0] base, input int idx);
        return ((int'(base) / 4 + idx) % 128) * 4;
    endfunction

    task automatic clear_samples();
        s_vst = -1; s_trply = -1; s_tiako = -1;
        s_ack_cnt = 0; s_ack_idx = -1;
        s_oe = 1'b0; s_overlap = 1'b0; s_vdal = '0;
    endtask

    task automatic sample_bus(input int cyc);
        if (bus.vec_st && s_vst < 0) begin
            s_vst  = cyc;
            s_vdal = bus.vec_dal;
        end
        if (bus.TRPLY && s_trply < 0) s_trply = cyc;
        if (bus.TIAKO && s_tiako < 0) s_tiako = cyc;
        if (bus.vec_oe) s_oe = 1'b1;
        if (bus.TRPLY && bus.TIAKO) s_overlap = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                s_ack_cnt++;
                s_ack_idx = i;
            end
        end
    endtask

    task automatic run_iak(input string tag);
        int         exp_idx;
        bit         exp_pass;
        int         fall;
        bit         idle_seen;
        logic [3:0] exp_tirq;

        exp_idx  = model_pick(req, model_ptr);
        exp_pass = (exp_idx < 0) || model_blocked(int'(int_priority), bus.RIRQ);
        exp_tirq = (req != '0) ? 4'(1 << int_priority) : 4'b0000;

        repeat (4) @(negedge clk);
        check_eq({tag, ".tirq"}, 32'(bus.TIRQ), 32'(exp_tirq));

        clear_samples();
        bus.RDIN  = 1'b1;
        bus.RIAKI = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            sample_bus(c);
            if (s_trply > 0 || s_tiako > 0) break;
        end

        if (exp_pass) begin
            check_eq({tag, ".tiako_rise"}, 32'(s_tiako >= 1 && s_tiako <= 3), 32'd1);
            bus.RDIN  = 1'b0;
            bus.RIAKI = 1'b0;
            fall = -1;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                sample_bus(c + 8);
                if (!bus.TIAKO) begin
                    fall = c;
                    break;
                end
            end
            check_eq({tag, ".tiako_fall"}, 32'(fall >= 2 && fall <= 3), 32'd1);
            check_eq({tag, ".no_reply"}, 32'((s_trply < 0) && !s_oe && (s_ack_cnt == 0)), 32'd1);
            repeat (3) @(negedge clk);
            check_eq({tag, ".tirq_after"}, 32'(bus.TIRQ), 32'(exp_tirq));
        end else begin
            check_eq({tag, ".vec_dal"}, 32'(s_vdal), 32'(model_vec(int_vector, exp_idx)));
            check_eq({tag, ".reply_lag"}, 32'(s_trply - s_vst), 32'd1);
            req[exp_idx] = 1'b0;
            bus.RDIN = 1'b0;
            fall = -1;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                sample_bus(c + 8);
                if (!bus.TRPLY) begin
                    fall = c;
                    break;
                end
            end
            check_eq({tag, ".trply_fall"}, 32'(fall >= 2 && fall <= 3), 32'd1);
            check_eq({tag, ".oe_done"}, 32'(bus.vec_oe), 32'd0);
            bus.RIAKI = 1'b0;
            idle_seen = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                sample_bus(c + 16);
                if (!busy) begin
                    idle_seen = 1'b1;
                    break;
                end
            end
            check_eq({tag, ".idle"}, 32'(idle_seen), 32'd1);
            check_eq({tag, ".ack_cnt"}, 32'(s_ack_cnt), 32'd1);
            check_eq({tag, ".ack_idx"}, 32'(s_ack_idx), 32'(exp_idx));
            check_eq({tag, ".no_tiako"}, 32'((s_tiako < 0) && !s_overlap), 32'd1);
            model_ptr = exp_idx;
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        model_ptr    = 0;
        reset_L      = 1'b0;
        req          = '0;
        int_vector   = '0;
        int_priority = '0;
        bus.RSYNC    = 1'b0;
        bus.RDIN     = 1'b0;
        bus.RIAKI    = 1'b0;
        bus.RIRQ     = '0;

        repeat (3) @(negedge clk);
        check_eq("rst.ctrl", 32'({busy, bus.TIRQ, bus.TIAKO, bus.TRPLY, bus.vec_oe, bus.vec_st}), 32'd0);
        check_eq("rst.dal", 32'(bus.vec_dal), 32'd0);
        check_eq("rst.ack", 32'(ack), 32'd0);
        reset_L = 1'b1;
        @(negedge clk);
        check_eq("rst.idle", 32'(busy), 32'd0);

        int_priority = 2'd0; int_vector = 9'o300; req = 4'b0100;
        run_iak("t1");

        req = 4'b0000;
        run_iak("t2");

        int_priority = 2'd0; req = 4'b0001; bus.RIRQ = 4'b0100;
        run_iak("t3");
        bus.RIRQ = 4'b0000;

        req = 4'b0010; int_priority = 2'd1;
        repeat (4) @(negedge clk);
        bus.RDIN  = 1'b1;
        bus.RIAKI = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.TRPLY) break;
        end
        check_eq("rst_mid.in_reply", 32'(bus.TRPLY), 32'd1);
        #5 reset_L = 1'b0;
        #1;
        check_eq("rst_mid.drop", 32'({busy, bus.TIRQ, bus.TIAKO, bus.TRPLY, bus.vec_oe}), 32'd0);
        bus.RDIN  = 1'b0;
        bus.RIAKI = 1'b0;
        req       = '0;
        model_ptr = 0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        #1;
        check_eq("rst_mid.idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_mid.stay", 32'(busy), 32'd0);

        int_vector = 9'o100; req = 4'b1001;
        run_iak("t4a");
`ifdef QINT_RR_EN
        check_eq("t4a.first", 32'(s_ack_idx), 32'd3);
`else
        check_eq("t4a.first", 32'(s_ack_idx), 32'd0);
`endif
        run_iak("t4b");

        int_vector = 9'o774; req = 4'b1000;
        run_iak("t5");
        check_eq("t5.wrap", 32'(s_vdal), 32'(16'o010));

        for (int t = 0; t < 40; t++) begin
            int_priority = 2'($urandom_range(0, 3));
            int_vector   = 9'($urandom);
            req          = 4'($urandom_range(0, 15));
            bus.RIRQ     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            run_iak($sformatf("rnd%0d", t));
            bus.RIRQ = 4'b0000;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
